bldc_motion_sequencer: RTL and testbench

- Command-side controller that sits in front of table_bldc_driver and sequences its enable, direction and pwm_duty inputs.
- Applies slew-limited duty ramps for all duty changes.
- Performs safe direction reversal: ramp down, coast, wait for rpm==0, re-enable in the new direction.
- Latches faults reported by the driver until software clears them.

---
 rtl/bldc_motion_sequencer_if.sv | 32 +++
 rtl/bldc_motion_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_bldc_motion_sequencer.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/bldc_motion_sequencer_if.sv
// Command channel for bldc_motion_sequencer plus the shared direction type.
// Ports: cmd_valid/cmd_direction/cmd_duty from master, cmd_ready from slave.
package bldc_motion_sequencer_pkg;
  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_CW   = 2'd1,
    DIR_CCW  = 2'd2
  } rotation_direction_t;
endpackage

interface bldc_motion_sequencer_if #(
  parameter int pwm_counter_width = 10
);
  logic cmd_valid;
  logic cmd_ready;
  bldc_motion_sequencer_pkg::rotation_direction_t cmd_direction;
  logic [pwm_counter_width-1:0] cmd_duty;

  modport master (
    output cmd_valid,
    output cmd_direction,
    output cmd_duty,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_direction,
    input  cmd_duty,
    output cmd_ready
  );
endinterface

// File: rtl/bldc_motion_sequencer.sv
// Slew-limited command sequencer in front of a BLDC driver.
// Ports: sys_clk/reset, cmd (slave), rpm/driver_state/hall_error/clear_fault
// in; drv_enable/drv_direction/drv_duty, seq_state, fault_code out.
module bldc_motion_sequencer
  import bldc_motion_sequencer_pkg::*;
#(
  parameter int clk_freq_hz       = 54_000_000,
  parameter int pwm_counter_width = 10,
  parameter int counter_width     = 32,
  parameter int ramp_step_us      = 100,
  parameter int ramp_step         = 1,
  parameter int max_duty          = 1000,
  parameter int stop_timeout_ms   = 500
) (
  input  logic                         sys_clk,
  input  logic                         reset,
  bldc_motion_sequencer_if.slave       cmd,
  input  logic [counter_width-1:0]     rpm,
  input  logic [2:0]                   driver_state,
  input  logic                         hall_error,
  input  logic                         clear_fault,
  output logic                         drv_enable,
  output rotation_direction_t          drv_direction,
  output logic [pwm_counter_width-1:0] drv_duty,
  output logic [2:0]                   seq_state,
  output logic [1:0]                   fault_code
);
  localparam int pw = pwm_counter_width;
  localparam int tick_cycles =
    (clk_freq_hz / 1_000_000) * ramp_step_us;
  localparam int stop_cycles =
    (clk_freq_hz / 1000) * stop_timeout_ms;
  localparam logic [pw-1:0] duty_max  = pw'(max_duty);
  localparam logic [pw-1:0] duty_step = pw'(ramp_step);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SLEW      = 3'd1,
    S_RUN       = 3'd2,
    S_STOPPING  = 3'd3,
    S_WAIT_STOP = 3'd4,
    S_FAULT     = 3'd5
  } state_t;

  state_t              state;
  logic [31:0]         presc;
  logic [31:0]         tmo;
  logic                tick;
  logic [pw-1:0]       tgt;
  rotation_direction_t pend_dir;
  logic [pw-1:0]       pend_duty;

  logic          accept;
  logic          cmd_go;
  logic          abort;
  logic          fault_hit;
  logic [pw-1:0] sat;
  logic [pw-1:0] goal;
  logic [pw-1:0] duty_nxt;

  function automatic logic [pw-1:0] step(
    input logic [pw-1:0] cur,
    input logic [pw-1:0] dst
  );
    if (cur < dst)
      return (dst - cur > duty_step) ? cur + duty_step : dst;
    else
      return (cur - dst > duty_step) ? cur - duty_step : dst;
  endfunction

  // Free-running: commands never re-phase the slew tick.
  assign tick = (presc == 32'(tick_cycles - 1));

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) presc <= '0;
    else if (tick) presc <= '0;
    else presc <= presc + 32'd1;
  end

  assign cmd.cmd_ready =
    !(state == S_WAIT_STOP || state == S_FAULT);
  assign seq_state = state;

  assign accept = cmd.cmd_valid & cmd.cmd_ready;
  assign sat = (cmd.cmd_duty > duty_max) ? duty_max : cmd.cmd_duty;
  assign cmd_go = (cmd.cmd_direction != DIR_NONE) && (sat != '0);
  // Same-direction run command: retarget without stopping.
  assign abort = accept && cmd_go &&
                 (cmd.cmd_direction == drv_direction);
  assign fault_hit =
    (state inside {S_SLEW, S_RUN, S_STOPPING, S_WAIT_STOP}) &&
    (hall_error || driver_state == 3'd3);

  // Goal seen by this cycle's tick, already folding in any new command.
  always_comb begin
    goal = '0;
    case (state)
      S_IDLE:         goal = sat;
      S_SLEW, S_RUN:  goal = accept ? (abort ? sat : '0) : tgt;
      S_STOPPING:     goal = abort ? sat : '0;
      default:        goal = '0;
    endcase
    duty_nxt = tick ? step(drv_duty, goal) : drv_duty;
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      drv_enable    <= 1'b0;
      drv_direction <= DIR_NONE;
      drv_duty      <= '0;
      fault_code    <= 2'd0;
      tgt           <= '0;
      pend_dir      <= DIR_NONE;
      pend_duty     <= '0;
      tmo           <= '0;
    end else if (fault_hit) begin
      state         <= S_FAULT;
      drv_enable    <= 1'b0;
      drv_direction <= DIR_NONE;
      drv_duty      <= '0;
      fault_code    <= hall_error ? 2'd1 : 2'd2;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept && cmd_go) begin
            tgt           <= sat;
            drv_direction <= cmd.cmd_direction;
            drv_enable    <= 1'b1;
            drv_duty      <= duty_nxt;
            state         <= S_SLEW;
          end
        end
        S_SLEW, S_RUN: begin
          drv_duty <= duty_nxt;
          if (accept && !abort) begin
            pend_dir  <= cmd.cmd_direction;
            pend_duty <= sat;
            state     <= S_STOPPING;
          end else begin
            if (abort) tgt <= sat;
            state <= (duty_nxt == goal) ? S_RUN : S_SLEW;
          end
        end
        S_STOPPING: begin
          drv_duty <= duty_nxt;
          if (abort) begin
            tgt   <= sat;
            state <= (duty_nxt == sat) ? S_RUN : S_SLEW;
          end else begin
            if (accept) begin
              pend_dir  <= cmd.cmd_direction;
              pend_duty <= sat;
            end
            if (duty_nxt == '0) begin
              state         <= S_WAIT_STOP;
              drv_enable    <= 1'b0;
              drv_direction <= DIR_NONE;
              tmo           <= '0;
            end
          end
        end
        S_WAIT_STOP: begin
          if (rpm == '0) begin
            if (pend_dir != DIR_NONE && pend_duty != '0) begin
              drv_enable    <= 1'b1;
              drv_direction <= pend_dir;
              tgt           <= pend_duty;
              state         <= S_SLEW;
            end else begin
              state <= S_IDLE;
            end
            pend_dir  <= DIR_NONE;
            pend_duty <= '0;
          end else if (tmo == 32'(stop_cycles - 1)) begin
            state      <= S_FAULT;
            fault_code <= 2'd3;
          end else begin
            tmo <= tmo + 32'd1;
          end
        end
        S_FAULT: begin
          if (clear_fault && !hall_error) begin
            state      <= S_IDLE;
            fault_code <= 2'd0;
            tgt        <= '0;
            pend_dir   <= DIR_NONE;
            pend_duty  <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bldc_motion_sequencer.sv
// Directed self-checking bench for bldc_motion_sequencer.
// Small test parameters: tick every 10 cycles, step 5, max 100, 1000-cycle timeout.
module tb_bldc_motion_sequencer;
  import bldc_motion_sequencer_pkg::*;

  logic        sys_clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] rpm = 32'd1200;
  logic [2:0]  driver_state = 3'd0;
  logic        hall_error = 1'b0;
  logic        clear_fault = 1'b0;
  logic        drv_enable;
  rotation_direction_t drv_direction;
  logic [9:0]  drv_duty;
  logic [2:0]  seq_state;
  logic [1:0]  fault_code;

  int n_assert = 0;
  int n_fail = 0;
  int prev = 0;

  bldc_motion_sequencer_if #(.pwm_counter_width(10)) cmd_if ();

  bldc_motion_sequencer #(
    .clk_freq_hz(1_000_000),
    .pwm_counter_width(10),
    .counter_width(32),
    .ramp_step_us(10),
    .ramp_step(5),
    .max_duty(100),
    .stop_timeout_ms(1)
  ) dut (
    .sys_clk(sys_clk),
    .reset(reset),
    .cmd(cmd_if),
    .rpm(rpm),
    .driver_state(driver_state),
    .hall_error(hall_error),
    .clear_fault(clear_fault),
    .drv_enable(drv_enable),
    .drv_direction(drv_direction),
    .drv_duty(drv_duty),
    .seq_state(seq_state),
    .fault_code(fault_code)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic send(input rotation_direction_t d, input int duty);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_direction = d;
    cmd_if.cmd_duty = 10'(duty);
    @(negedge sys_clk);
    cmd_if.cmd_valid = 1'b0;
  endtask

  task automatic pulse_clear();
    clear_fault = 1'b1;
    @(negedge sys_clk);
    clear_fault = 1'b0;
  endtask

  task automatic step_to(input int exp, input bit gap_chk,
                         input string tag);
    int gap;
    gap = 0;
    while (int'(drv_duty) == prev && gap < 40) begin
      @(negedge sys_clk);
      gap++;
    end
    chk({tag, "_duty"}, int'(drv_duty), exp);
    if (gap_chk) chk({tag, "_gap"}, gap, 10);
    prev = int'(drv_duty);
  endtask

  task automatic ramp(input int to, input string tag);
    bit first;
    int nx;
    int guard;
    first = 1'b1;
    guard = 0;
    while (prev != to && guard < 30) begin
      if (prev < to) nx = (to - prev > 5) ? prev + 5 : to;
      else nx = (prev - to > 5) ? prev - 5 : to;
      step_to(nx, !first, tag);
      first = 1'b0;
      guard++;
    end
  endtask

  initial begin
    int n;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_direction = DIR_NONE;
    cmd_if.cmd_duty = '0;

    repeat (3) @(negedge sys_clk);
    chk("rst_state", int'(seq_state), 0);
    chk("rst_en", int'(drv_enable), 0);
    chk("rst_dir", int'(drv_direction), 0);
    chk("rst_duty", int'(drv_duty), 0);
    chk("rst_fault", int'(fault_code), 0);
    chk("rst_ready", int'(cmd_if.cmd_ready), 1);
    reset = 1'b0;
    @(negedge sys_clk);

    // Start CW/40 from IDLE
    prev = 0;
    send(DIR_CW, 40);
    chk("start_state", int'(seq_state), 1);
    chk("start_en", int'(drv_enable), 1);
    chk("start_dir", int'(drv_direction), int'(DIR_CW));
    ramp(40, "start");
    chk("start_run", int'(seq_state), 2);
    repeat (15) @(negedge sys_clk);
    chk("run_hold", int'(drv_duty), 40);

    // Reversal to CCW/20
    send(DIR_CCW, 20);
    chk("rev_stopping", int'(seq_state), 3);
    ramp(0, "rev_down");
    chk("rev_wait", int'(seq_state), 4);
    chk("rev_wait_en", int'(drv_enable), 0);
    chk("rev_wait_dir", int'(drv_direction), 0);
    chk("rev_wait_ready", int'(cmd_if.cmd_ready), 0);
    rpm = 32'd0;
    @(negedge sys_clk);
    rpm = 32'd1200;
    chk("rev_slew", int'(seq_state), 1);
    chk("rev_dir", int'(drv_direction), int'(DIR_CCW));
    chk("rev_en", int'(drv_enable), 1);
    ramp(20, "rev_up");
    chk("rev_run", int'(seq_state), 2);

    // Hall fault in RUN
    hall_error = 1'b1;
    @(negedge sys_clk);
    chk("hall_state", int'(seq_state), 5);
    chk("hall_code", int'(fault_code), 1);
    chk("hall_duty", int'(drv_duty), 0);
    chk("hall_en", int'(drv_enable), 0);
    chk("hall_ready", int'(cmd_if.cmd_ready), 0);
    pulse_clear();
    chk("hall_clr_ign", int'(seq_state), 5);
    chk("hall_code_held", int'(fault_code), 1);
    hall_error = 1'b0;
    @(negedge sys_clk);
    pulse_clear();
    chk("hall_clr_state", int'(seq_state), 0);
    chk("hall_clr_code", int'(fault_code), 0);

    // Zero-duty command in IDLE is ignored
    send(DIR_CW, 0);
    @(negedge sys_clk);
    chk("idle_ign_state", int'(seq_state), 0);
    chk("idle_ign_en", int'(drv_enable), 0);

    // Saturation CW/250 -> 100
    prev = 0;
    send(DIR_CW, 250);
    chk("sat_state", int'(seq_state), 1);
    ramp(100, "sat");
    chk("sat_run", int'(seq_state), 2);
    repeat (12) @(negedge sys_clk);
    chk("sat_hold", int'(drv_duty), 100);

    // Abort a stop at duty 25
    send(DIR_CCW, 20);
    chk("abort_stopping", int'(seq_state), 3);
    ramp(25, "abort_down");
    send(DIR_CW, 60);
    chk("abort_slew", int'(seq_state), 1);
    chk("abort_duty", int'(drv_duty), 25);
    chk("abort_en", int'(drv_enable), 1);
    ramp(60, "abort_up");
    chk("abort_run", int'(seq_state), 2);

    // Stop with rpm stuck -> timeout fault
    send(DIR_NONE, 0);
    chk("tmo_stopping", int'(seq_state), 3);
    ramp(0, "tmo_down");
    chk("tmo_wait", int'(seq_state), 4);
    n = 0;
    while (seq_state != 3'd5 && n < 1100) begin
      @(negedge sys_clk);
      n++;
    end
    chk("tmo_cycles", n, 1000);
    chk("tmo_code", int'(fault_code), 3);
    pulse_clear();
    chk("tmo_clr", int'(seq_state), 0);
    chk("tmo_clr_code", int'(fault_code), 0);

    // Driver error during SLEW
    prev = 0;
    send(DIR_CW, 40);
    repeat (3) @(negedge sys_clk);
    driver_state = 3'd3;
    @(negedge sys_clk);
    driver_state = 3'd0;
    chk("drv_err_state", int'(seq_state), 5);
    chk("drv_err_code", int'(fault_code), 2);
    chk("drv_err_duty", int'(drv_duty), 0);
    pulse_clear();
    chk("drv_err_clr", int'(seq_state), 0);

    // Asynchronous reset mid-ramp
    send(DIR_CW, 60);
    repeat (25) @(negedge sys_clk);
    chk("mid_slew", int'(seq_state), 1);
    #2 reset = 1'b1;
    #1;
    chk("arst_state", int'(seq_state), 0);
    chk("arst_en", int'(drv_enable), 0);
    chk("arst_dir", int'(drv_direction), 0);
    chk("arst_duty", int'(drv_duty), 0);
    chk("arst_ready", int'(cmd_if.cmd_ready), 1);
    repeat (2) @(negedge sys_clk);
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end
endmodule
